// File: rtl/digits10_decoder.sv
// Streaming 5x5 glyph recognizer: accepts one bitmap row per handshake and
// reports which digit 0-9 the completed bitmap matches (4'hF on a miss).
module digits10_decoder #(
  parameter bit MIRROR = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       row_valid,
  output logic       row_ready,
  input  logic [4:0] row_data,
  input  logic       row_sof,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_hit
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e      state_q;
  logic [2:0]  row_idx_q, row_idx_d;
  logic [9:0]  cand_q, cand_d;
  logic [3:0]  out_digit_q;
  logic        out_hit_q;

  logic [2:0]  eff_idx;
  logic [9:0]  eff_mask;
  logic [9:0]  match;
  logic [4:0]  row_cmp;
  logic [3:0]  hit_digit;

  // Glyph table, packed row 0 in the top five bits.
  function automatic logic [4:0] glyph_row(input logic [3:0] d, input logic [2:0] r);
    logic [24:0] g;
    case (d)
      4'd0:    g = 25'b11111_10001_10001_10001_11111;
      4'd1:    g = 25'b01100_00100_00100_00100_11111;
      4'd2:    g = 25'b11111_00001_11111_10000_11111;
      4'd3:    g = 25'b11111_00001_11111_00001_11111;
      4'd4:    g = 25'b10001_10001_11111_00001_00001;
      4'd5:    g = 25'b11111_10000_11111_00001_11111;
      4'd6:    g = 25'b11111_10000_11111_10001_11111;
      4'd7:    g = 25'b11111_00001_00001_00001_00001;
      4'd8:    g = 25'b11111_10001_11111_10001_11111;
      4'd9:    g = 25'b11111_10001_11111_00001_11111;
      default: g = '0;
    endcase
    case (r)
      3'd0:    return g[24:20];
      3'd1:    return g[19:15];
      3'd2:    return g[14:10];
      3'd3:    return g[9:5];
      default: return g[4:0];
    endcase
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    row_cmp = row_data;
    if (MIRROR) begin
      for (int b = 0; b < 5; b++) row_cmp[b] = row_data[4-b];
    end

    eff_idx  = row_sof ? 3'd0 : row_idx_q;
    eff_mask = (eff_idx == 3'd0) ? 10'h3FF : cand_q;

    match = '0;
    for (int d = 0; d < 10; d++) begin
      match[d] = (glyph_row(4'(d), eff_idx) == row_cmp);
    end
    cand_d    = eff_mask & match;
    row_idx_d = eff_idx + 3'd1;

    // Glyphs are unique, so at most one candidate survives the last row.
    hit_digit = 4'hF;
    for (int d = 0; d < 10; d++) begin
      if (cand_d[d]) hit_digit = 4'(d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACCUM;
      row_idx_q   <= 3'd0;
      cand_q      <= 10'h3FF;
      out_digit_q <= 4'd0;
      out_hit_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (row_valid) begin
            if (eff_idx == 3'd4) begin
              state_q     <= DONE;
              row_idx_q   <= 3'd0;
              cand_q      <= 10'h3FF;
              out_hit_q   <= |cand_d;
              out_digit_q <= hit_digit;
            end else begin
              row_idx_q <= row_idx_d;
              cand_q    <= cand_d;
            end
          end
        end
        DONE: begin
          if (out_ready) state_q <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign row_ready = !out_valid;
  assign out_digit = out_digit_q;
  assign out_hit   = out_hit_q;

endmodule

// File: tb/tb_digits10_decoder.sv
// Randomized scoreboard bench for digits10_decoder: frames are decoded by a
// whole-bitmap reference model and compared when the DUT hands off a result.
module tb_digits10_decoder;

  localparam bit MIRROR = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       row_valid = 1'b0;
  logic       row_ready;
  logic [4:0] row_data = '0;
  logic       row_sof = 1'b0;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_hit;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] digit;
    logic       hit;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] frame_q[$];

  logic [24:0] glyphs [10] = '{
    25'b11111_10001_10001_10001_11111,
    25'b01100_00100_00100_00100_11111,
    25'b11111_00001_11111_10000_11111,
    25'b11111_00001_11111_00001_11111,
    25'b10001_10001_11111_00001_00001,
    25'b11111_10000_11111_00001_11111,
    25'b11111_10000_11111_10001_11111,
    25'b11111_00001_00001_00001_00001,
    25'b11111_10001_11111_10001_11111,
    25'b11111_10001_11111_00001_11111
  };

  bit ready_rand  = 1'b0;
  bit ready_force = 1'b1;

  bit         mon_hold = 1'b0;
  logic [3:0] mon_digit;
  logic       mon_hit;

  digits10_decoder #(.MIRROR(MIRROR)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_sof   (row_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_hit   (out_hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] row_of(input logic [24:0] bm, input int r);
    return bm[24-5*r -: 5];
  endfunction

  function automatic logic [4:0] rev5(input logic [4:0] v);
    logic [4:0] o;
    for (int b = 0; b < 5; b++) o[b] = v[4-b];
    return o;
  endfunction

  function automatic exp_t ref_decode(input logic [24:0] bm);
    exp_t e;
    e.digit = 4'hF;
    e.hit   = 1'b0;
    for (int d = 0; d < 10; d++) begin
      if (bm == glyphs[d]) begin
        e.digit = 4'(d);
        e.hit   = 1'b1;
      end
    end
    return e;
  endfunction

  // Reference model: collect logical rows of a frame; a sof restarts the frame.
  function automatic bit model_accept(input logic [4:0] row, input logic sof);
    logic [24:0] bm;
    if (sof) frame_q.delete();
    frame_q.push_back(row);
    if (frame_q.size() == 5) begin
      bm = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
      sb.push_back(ref_decode(bm));
      frame_q.delete();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_row(input logic [4:0] row, input logic sof);
    bit acc;
    int n;
    row_valid = 1'b1;
    row_data  = MIRROR ? rev5(row) : row;
    row_sof   = sof;
    n = 0;
    do begin
      acc = row_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    row_valid = 1'b0;
    row_sof   = 1'b0;
    if (!acc) begin
      check("row_accept_timeout", 32'd0, 32'd1);
    end else if (model_accept(row, sof)) begin
      check("result_latency", out_valid, 1'b1);
    end
  endtask

  task automatic send_bitmap(input logic [24:0] bm, input logic sof0, input int gap_max);
    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(0, gap_max)) @(posedge clk);
      #0;
      send_row(row_of(bm, r), (r == 0) ? sof0 : 1'b0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_digit", out_digit, 4'd0);
    check("rst_out_hit", out_hit, 1'b0);
    check("rst_row_ready", row_ready, 1'b1);
    sb.delete();
    frame_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor: pops the scoreboard on each output handshake and checks hold stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && out_valid === 1'b1) begin
        if (mon_hold) begin
          check("hold_digit", out_digit, mon_digit);
          check("hold_hit", out_hit, mon_hit);
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("out_digit", out_digit, e.digit);
            check("out_hit", out_hit, e.hit);
          end
        end
        mon_hold  = !out_ready;
        mon_digit = out_digit;
        mon_hit   = out_hit;
      end else begin
        mon_hold = 1'b0;
      end
      check("row_ready_inv", row_ready, !out_valid);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [24:0] bm;
    int kind;
    #1;
    do_reset();

    // Every digit in order, with sof on row 0 and downstream always ready.
    ready_force = 1'b1;
    send_bitmap(glyphs[2], 1'b1, 0);
    for (int d = 0; d < 10; d++) send_bitmap(glyphs[d], 1'b1, 0);
    drain();

    // Misses, including an early miss that must still consume exactly five rows.
    send_bitmap({5{5'b10101}}, 1'b1, 0);
    bm = {5'b00000, glyphs[8][19:0]};
    send_bitmap(bm, 1'b1, 0);
    send_bitmap(glyphs[8], 1'b0, 0);
    drain();

    // Backpressure: result held while rows are offered and refused.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_bitmap(glyphs[7], 1'b1, 0);
    row_valid = 1'b1;
    row_data  = 5'b11111;
    row_sof   = 1'b1;
    repeat (4) begin
      check("bp_row_ready", row_ready, 1'b0);
      check("bp_digit", out_digit, 4'd7);
      check("bp_hit", out_hit, 1'b1);
      @(posedge clk);
      #1;
    end
    row_valid   = 1'b0;
    row_sof     = 1'b0;
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", row_ready, 1'b1);
    send_bitmap(glyphs[1], 1'b1, 0);
    drain();

    // Resync: a partial digit 3 is abandoned by a new sof.
    send_row(row_of(glyphs[3], 0), 1'b1);
    send_row(row_of(glyphs[3], 1), 1'b0);
    send_bitmap(glyphs[0], 1'b1, 0);
    drain();

    // Reset mid-frame and while a result is pending.
    for (int r = 0; r < 3; r++) send_row(row_of(glyphs[5], r), r == 0);
    do_reset();
    send_bitmap(glyphs[9], 1'b1, 0);
    drain();
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_bitmap(glyphs[4], 1'b1, 0);
    do_reset();
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", out_valid, 1'b0);
    send_bitmap(glyphs[9], 1'b1, 0);
    drain();

    // Randomized frames, pixel errors, partial frames, gaps and output stalls.
    ready_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      bm   = glyphs[$urandom_range(0, 9)];
      case (kind)
        0, 1: send_bitmap(bm, 1'b1, 2);
        2: begin
          bm[$urandom_range(0, 24)] ^= 1'b1;
          send_bitmap(bm, 1'b1, 1);
        end
        3: begin
          for (int r = 0; r < int'($urandom_range(1, 4)); r++) send_row(row_of(bm, r), r == 0);
        end
        default: send_bitmap(25'($urandom), 1'b1, 1);
      endcase
    end
    ready_rand  = 1'b0;
    ready_force = 1'b1;
    send_bitmap(glyphs[6], 1'b1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
